// File: rtl/psion_lcd_capture.sv
// Psion 5MX LCD bus receiver: oversamples the panel lines, rebuilds nibble pairs into
// framebuffer bytes and emits single-cycle write strobes with {row, byte-column} addresses.
module psion_lcd_capture #(
  parameter int unsigned WIDTH  = 160,
  parameter int unsigned HEIGHT = 240,
  parameter int unsigned X_BITS = 7,
  parameter bit          INVERT = 1'b1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                lcd_clk,
  input  logic                lcd_row,
  input  logic                lcd_frame,
  input  logic                lcd_enable,
  input  logic [3:0]          lcd_data,
  output logic                wr_en,
  output logic [8+X_BITS-1:0] wr_addr,
  output logic [7:0]          wr_data,
  output logic                frame_done,
  output logic                locked,
  output logic                overrun,
  input  logic                clear_err
);

  localparam int unsigned AW = 8 + X_BITS;
  localparam int unsigned IW = X_BITS + 1;

  // Bit layout of the sampled bus: [0]=clk [1]=row [2]=frame [3]=enable [7:4]=data
  localparam int unsigned B_CLK = 0;
  localparam int unsigned B_ROW = 1;
  localparam int unsigned B_FRM = 2;
  localparam int unsigned B_EN  = 3;

  typedef enum logic {
    WAIT_FRAME = 1'b0,
    ACTIVE     = 1'b1
  } state_t;

  logic [7:0]    sync1_q;
  logic [7:0]    sync2_q;
  logic [1:0]    hist_q;

  logic          clk_rise_q;
  logic          row_rise_q;
  logic          frame_q;
  logic          enable_q;
  logic [3:0]    data_q;

  state_t        state_q;
  logic [7:0]    y_q;
  logic [X_BITS-1:0] xb_q;
  logic          phase_q;
  logic [3:0]    n0_q;

  logic          wr_en_q;
  logic [AW-1:0] wr_addr_q;
  logic [7:0]    wr_data_q;
  logic          frame_done_q;
  logic          locked_q;
  logic          overrun_q;

  logic [IW-1:0] pos_c;
  logic          row_full_c;
  logic          frame_full_c;
  logic          frame_mark_c;
  logic [3:0]    nib_c;
  logic          err_c;

  // Two-flop synchronizer plus history flop for edge detection on clk/row
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q <= '0;
      sync2_q <= '0;
      hist_q  <= '0;
    end else begin
      sync1_q <= {lcd_data, lcd_enable, lcd_frame, lcd_row, lcd_clk};
      sync2_q <= sync1_q;
      hist_q  <= sync2_q[1:0];
    end
  end

  // Event stage: edges and level lines registered together so the nibble stays aligned
  always_ff @(posedge clk) begin
    if (reset) begin
      clk_rise_q <= 1'b0;
      row_rise_q <= 1'b0;
      frame_q    <= 1'b0;
      enable_q   <= 1'b0;
      data_q     <= '0;
    end else begin
      clk_rise_q <= sync2_q[B_CLK] & ~hist_q[B_CLK];
      row_rise_q <= sync2_q[B_ROW] & ~hist_q[B_ROW];
      frame_q    <= sync2_q[B_FRM];
      enable_q   <= sync2_q[B_EN];
      data_q     <= sync2_q[7:4];
    end
  end

  always_comb begin
    pos_c        = {xb_q, phase_q};
    row_full_c   = (pos_c >= IW'(WIDTH));
    frame_full_c = (32'(y_q) >= HEIGHT);
    frame_mark_c = row_rise_q & frame_q;
    nib_c        = INVERT ? ~data_q : data_q;
    err_c        = 1'b0;
    if (enable_q && (state_q == ACTIVE)) begin
      if (row_rise_q) begin
        err_c = phase_q;
      end else if (clk_rise_q) begin
        err_c = row_full_c | (phase_q & frame_full_c);
      end
    end
  end

  // Capture FSM with registered outputs; a row event always takes priority over a clock event
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= WAIT_FRAME;
      y_q          <= '0;
      xb_q         <= '0;
      phase_q      <= 1'b0;
      n0_q         <= '0;
      wr_en_q      <= 1'b0;
      wr_addr_q    <= '0;
      wr_data_q    <= '0;
      frame_done_q <= 1'b0;
      locked_q     <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      wr_en_q      <= 1'b0;
      frame_done_q <= 1'b0;
      overrun_q    <= (overrun_q & ~clear_err) | err_c;
      if (!enable_q) begin
        state_q  <= WAIT_FRAME;
        locked_q <= 1'b0;
      end else begin
        case (state_q)
          WAIT_FRAME: begin
            if (frame_mark_c) begin
              y_q      <= '0;
              xb_q     <= '0;
              phase_q  <= 1'b0;
              state_q  <= ACTIVE;
              locked_q <= 1'b1;
            end
          end
          ACTIVE: begin
            locked_q <= 1'b1;
            if (row_rise_q) begin
              xb_q    <= '0;
              phase_q <= 1'b0;
              if (frame_q) begin
                y_q          <= '0;
                frame_done_q <= 1'b1;
              end else if (y_q != 8'hFF) begin
                y_q <= y_q + 8'd1;
              end
            end else if (clk_rise_q && !row_full_c) begin
              if (!phase_q) begin
                n0_q    <= nib_c;
                phase_q <= 1'b1;
              end else begin
                if (!frame_full_c) begin
                  wr_en_q   <= 1'b1;
                  wr_data_q <= {n0_q, nib_c};
                  wr_addr_q <= {y_q, xb_q};
                end
                xb_q    <= xb_q + X_BITS'(1);
                phase_q <= 1'b0;
              end
            end
          end
          default: begin
            state_q  <= WAIT_FRAME;
            locked_q <= 1'b0;
          end
        endcase
      end
    end
  end

  assign wr_en      = wr_en_q;
  assign wr_addr    = wr_addr_q;
  assign wr_data    = wr_data_q;
  assign frame_done = frame_done_q;
  assign locked     = locked_q;
  assign overrun    = overrun_q;

endmodule

// File: tb/tb_psion_lcd_capture.sv
// Directed bench for psion_lcd_capture: a full-size instance plus a small-geometry
// instance (8x6) that makes a complete frame and the frame-overflow boundary affordable.
module tb_psion_lcd_capture;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        lcd_clk = 1'b0, lcd_row = 1'b0, lcd_frame = 1'b0, lcd_enable = 1'b0;
  logic [3:0]  lcd_data = 4'h0;
  logic        clear_err = 1'b0;

  logic        wr_en, frame_done, locked, overrun;
  logic [14:0] wr_addr;
  logic [7:0]  wr_data;
  logic        s_wr_en, s_frame_done, s_locked, s_overrun;
  logic [10:0] s_wr_addr;
  logic [7:0]  s_wr_data;

  int checks = 0;
  int errors = 0;
  int wcnt = 0, fcnt = 0, scnt = 0, sfcnt = 0;
  logic [14:0] last_addr = '0;
  logic [7:0]  last_data = '0;
  logic [10:0] cap_a [64];
  logic [7:0]  cap_d [64];

  psion_lcd_capture dut (
    .clk(clk), .reset(reset), .lcd_clk(lcd_clk), .lcd_row(lcd_row), .lcd_frame(lcd_frame),
    .lcd_enable(lcd_enable), .lcd_data(lcd_data), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .frame_done(frame_done), .locked(locked), .overrun(overrun),
    .clear_err(clear_err)
  );

  psion_lcd_capture #(.WIDTH(8), .HEIGHT(6), .X_BITS(3), .INVERT(1'b1)) dut_s (
    .clk(clk), .reset(reset), .lcd_clk(lcd_clk), .lcd_row(lcd_row), .lcd_frame(lcd_frame),
    .lcd_enable(lcd_enable), .lcd_data(lcd_data), .wr_en(s_wr_en), .wr_addr(s_wr_addr),
    .wr_data(s_wr_data), .frame_done(s_frame_done), .locked(s_locked), .overrun(s_overrun),
    .clear_err(clear_err)
  );

  always #5 clk = ~clk;

  // Write/frame-done monitor sampled 1 time unit after each rising edge
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (wr_en) begin
        wcnt++;
        last_addr = wr_addr;
        last_data = wr_data;
      end
      if (frame_done) fcnt++;
      if (s_wr_en) begin
        cap_a[scnt % 64] = s_wr_addr;
        cap_d[scnt % 64] = s_wr_data;
        scnt++;
      end
      if (s_frame_done) sfcnt++;
    end
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // One panel nibble (logical value v, driven inverted), clock high 2 and low 2 cycles
  task automatic nib(input logic [3:0] v);
    @(negedge clk);
    lcd_data = ~v;
    lcd_clk  = 1'b1;
    idle(2);
    lcd_clk  = 1'b0;
    idle(1);
  endtask

  task automatic row_pulse(input logic frm);
    @(negedge clk);
    lcd_row   = 1'b1;
    lcd_frame = frm;
    idle(2);
    lcd_row   = 1'b0;
    idle(2);
    lcd_frame = 1'b0;
  endtask

  task automatic pulse_clear();
    @(negedge clk);
    clear_err = 1'b1;
    @(negedge clk);
    clear_err = 1'b0;
    idle(2);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    idle(3);
    checks++;
    if ({wr_en, wr_addr, wr_data, frame_done, locked, overrun} !== 27'd0) begin
      errors++;
      $display("FAIL reset_outputs: got en=%b addr=%h data=%h fd=%b lk=%b ov=%b, want all 0",
               wr_en, wr_addr, wr_data, frame_done, locked, overrun);
    end
    reset = 1'b0;
    idle(2);
  endtask

  task automatic test_sync_acquire();
    int w0, f0;
    lcd_enable = 1'b1;
    idle(4);
    w0 = wcnt;
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < 4; i++) nib(4'(i));
      row_pulse(1'b0);
    end
    idle(6);
    checks++;
    if (wcnt - w0 !== 0) begin errors++; $display("FAIL acquire_no_writes: got %0d writes, want 0", wcnt - w0); end
    checks++;
    if (locked !== 1'b0) begin errors++; $display("FAIL acquire_unlocked: got %b, want 0", locked); end
    f0 = fcnt;
    row_pulse(1'b1);
    idle(6);
    checks++;
    if (locked !== 1'b1) begin errors++; $display("FAIL acquire_locked: got %b, want 1", locked); end
    checks++;
    if (fcnt - f0 !== 0) begin errors++; $display("FAIL acquire_no_fd: got %0d pulses, want 0", fcnt - f0); end
  endtask

  task automatic test_byte_assembly();
    int w0;
    logic en2, en3, en4;
    logic [7:0] d3;
    logic [14:0] a3;
    w0 = wcnt;
    nib(4'h1);
    @(negedge clk);
    lcd_data = ~4'h2;
    lcd_clk  = 1'b1;
    @(posedge clk);            // edge N: first synchronizer flop samples lcd_clk=1
    repeat (2) @(posedge clk);
    #1 en2 = wr_en;
    @(posedge clk);
    #1 begin en3 = wr_en; d3 = wr_data; a3 = wr_addr; end
    @(posedge clk);
    #1 en4 = wr_en;
    @(negedge clk);
    lcd_clk = 1'b0;
    idle(6);
    checks++;
    if ({en2, en3, en4} !== 3'b010) begin
      errors++; $display("FAIL byte_latency: wr_en at N+2,N+3,N+4 got %b%b%b, want 010", en2, en3, en4);
    end
    checks++;
    if (d3 !== 8'h12) begin errors++; $display("FAIL byte_data: got %h, want 12", d3); end
    checks++;
    if (a3 !== 15'd0) begin errors++; $display("FAIL byte_addr: got %h, want 0", a3); end
    checks++;
    if (wcnt - w0 !== 1) begin errors++; $display("FAIL byte_count: got %0d, want 1", wcnt - w0); end
  endtask

  task automatic test_row_overflow();
    int w0;
    row_pulse(1'b0);
    idle(4);
    w0 = wcnt;
    for (int i = 0; i < 162; i++) nib(4'(i));
    idle(6);
    checks++;
    if (wcnt - w0 !== 80) begin errors++; $display("FAIL rowov_count: got %0d, want 80", wcnt - w0); end
    checks++;
    if (last_addr !== {8'd1, 7'd79}) begin errors++; $display("FAIL rowov_last_addr: got %h, want %h", last_addr, {8'd1, 7'd79}); end
    checks++;
    if (last_data !== 8'hEF) begin errors++; $display("FAIL rowov_last_data: got %h, want ef", last_data); end
    checks++;
    if (overrun !== 1'b1) begin errors++; $display("FAIL rowov_overrun: got %b, want 1", overrun); end
    pulse_clear();
    checks++;
    if (overrun !== 1'b0) begin errors++; $display("FAIL rowov_clear: got %b, want 0", overrun); end
  endtask

  task automatic test_odd_nibble();
    int w0;
    row_pulse(1'b0);
    idle(4);
    w0 = wcnt;
    nib(4'hA); nib(4'h5); nib(4'h3);
    idle(6);
    checks++;
    if (wcnt - w0 !== 1 || last_addr !== {8'd2, 7'd0} || last_data !== 8'hA5) begin
      errors++; $display("FAIL odd_first: got n=%0d addr=%h data=%h, want n=1 addr=%h data=a5",
                         wcnt - w0, last_addr, last_data, {8'd2, 7'd0});
    end
    checks++;
    if (overrun !== 1'b0) begin errors++; $display("FAIL odd_pre_ov: got %b, want 0", overrun); end
    row_pulse(1'b0);
    idle(4);
    checks++;
    if (overrun !== 1'b1) begin errors++; $display("FAIL odd_overrun: got %b, want 1", overrun); end
    nib(4'h6); nib(4'h9);
    idle(6);
    checks++;
    if (wcnt - w0 !== 2 || last_addr !== {8'd3, 7'd0} || last_data !== 8'h69) begin
      errors++; $display("FAIL odd_next_row: got n=%0d addr=%h data=%h, want n=2 addr=%h data=69",
                         wcnt - w0, last_addr, last_data, {8'd3, 7'd0});
    end
    pulse_clear();
  endtask

  task automatic test_full_frame();
    int s0, f0, bad;
    logic [7:0] b;
    row_pulse(1'b1);
    idle(4);
    pulse_clear();
    s0 = scnt;
    f0 = sfcnt;
    for (int y = 0; y < 6; y++) begin
      for (int x = 0; x < 4; x++) begin
        b = 8'(y + x);
        nib(b[7:4]);
        nib(b[3:0]);
      end
      if (y < 5) row_pulse(1'b0);
    end
    row_pulse(1'b1);
    idle(6);
    checks++;
    if (scnt - s0 !== 24) begin errors++; $display("FAIL frame_count: got %0d, want 24", scnt - s0); end
    bad = 0;
    for (int i = 0; i < 24; i++) begin
      b = 8'((i / 4) + (i % 4));
      if (cap_a[(s0 + i) % 64] !== {8'(i / 4), 3'(i % 4)} || cap_d[(s0 + i) % 64] !== b) bad++;
    end
    checks++;
    if (bad !== 0) begin errors++; $display("FAIL frame_content: got %0d wrong writes, want 0", bad); end
    checks++;
    if (cap_a[(s0 + 23) % 64] !== {8'd5, 3'd3}) begin
      errors++; $display("FAIL frame_last_addr: got %h, want %h", cap_a[(s0 + 23) % 64], {8'd5, 3'd3});
    end
    checks++;
    if (sfcnt - f0 !== 1) begin errors++; $display("FAIL frame_done_count: got %0d, want 1", sfcnt - f0); end
    checks++;
    if (s_overrun !== 1'b0) begin errors++; $display("FAIL frame_overrun: got %b, want 0", s_overrun); end
  endtask

  task automatic test_frame_overflow();
    int s0;
    for (int i = 0; i < 6; i++) row_pulse(1'b0);
    idle(4);
    s0 = scnt;
    nib(4'h1); nib(4'h2);
    idle(6);
    checks++;
    if (scnt - s0 !== 0) begin errors++; $display("FAIL frameov_suppressed: got %0d writes, want 0", scnt - s0); end
    checks++;
    if (s_overrun !== 1'b1) begin errors++; $display("FAIL frameov_overrun: got %b, want 1", s_overrun); end
    pulse_clear();
  endtask

  task automatic test_enable_drop();
    int w0, f0;
    row_pulse(1'b1);
    for (int i = 0; i < 10; i++) row_pulse(1'b0);
    nib(4'hC); nib(4'h3);
    idle(6);
    checks++;
    if (last_addr !== {8'd10, 7'd0} || last_data !== 8'hC3) begin
      errors++; $display("FAIL en_row10_write: got addr=%h data=%h, want addr=%h data=c3", last_addr, last_data, {8'd10, 7'd0});
    end
    @(negedge clk);
    lcd_enable = 1'b0;
    idle(6);
    checks++;
    if (locked !== 1'b0) begin errors++; $display("FAIL en_drop_unlock: got %b, want 0", locked); end
    lcd_enable = 1'b1;
    idle(4);
    w0 = wcnt;
    nib(4'h1); nib(4'h2); row_pulse(1'b0); nib(4'h3); nib(4'h4);
    idle(6);
    checks++;
    if (wcnt - w0 !== 0 || locked !== 1'b0) begin
      errors++; $display("FAIL en_wait_frame: got writes=%0d locked=%b, want 0 and 0", wcnt - w0, locked);
    end
    f0 = fcnt;
    row_pulse(1'b1);
    idle(4);
    checks++;
    if (locked !== 1'b1 || fcnt - f0 !== 0) begin
      errors++; $display("FAIL en_relock: got locked=%b fd=%0d, want 1 and 0", locked, fcnt - f0);
    end
    nib(4'h7); nib(4'h8);
    idle(6);
    checks++;
    if (wcnt - w0 !== 1 || last_addr !== 15'd0 || last_data !== 8'h78) begin
      errors++; $display("FAIL en_relock_write: got n=%0d addr=%h data=%h, want 1 0 78", wcnt - w0, last_addr, last_data);
    end
  endtask

  task automatic test_reset_mid();
    int w0;
    w0 = wcnt;
    nib(4'h5);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if ({wr_en, wr_addr, wr_data, frame_done, locked, overrun} !== 27'd0) begin
      errors++; $display("FAIL reset_mid_outputs: got en=%b addr=%h data=%h fd=%b lk=%b ov=%b, want all 0",
                         wr_en, wr_addr, wr_data, frame_done, locked, overrun);
    end
    idle(1);
    reset = 1'b0;
    nib(4'h6);
    idle(6);
    checks++;
    if (wcnt - w0 !== 0 || locked !== 1'b0) begin
      errors++; $display("FAIL reset_mid_no_write: got writes=%0d locked=%b, want 0 and 0", wcnt - w0, locked);
    end
  endtask

  initial begin
    test_reset();
    test_sync_acquire();
    test_byte_assembly();
    test_row_overflow();
    test_odd_nibble();
    test_full_frame();
    test_frame_overflow();
    test_enable_drop();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/psion_lcd_capture.md
Name: psion_lcd_capture

Overview:
Receive side of the Psion 5MX LCD panel bus. Oversamples the panel's frame, load/row, clock, enable and 4-bit data lines with the 24 MHz system clock. Reassembles nibble pairs into framebuffer bytes and issues single-cycle write strobes with row/column addresses. Sits between the LCD connector GPIOs and a framebuffer write port, so a genuine Psion mainboard's display output can be captured and forwarded, for example over the UART.

Parameters:
WIDTH, 160, nibbles per row (640 px / 4)
HEIGHT, 240, rows per frame
X_BITS, 7, byte-column address width (WIDTH/2 = 80 bytes max)
INVERT, 1, 1 = invert each captured nibble (the panel bus carries inverted pixel data)

Ports:
clk  in  1  system clock, 24 MHz
reset  in  1  synchronous, active-high
lcd_clk  in  1  panel pixel clock, asynchronous
lcd_row  in  1  panel row/load strobe, asynchronous
lcd_frame  in  1  panel frame marker, asynchronous
lcd_enable  in  1  panel enable, high = enabled, asynchronous
lcd_data  in  4  panel nibble data, asynchronous
wr_en  out  1  one-cycle framebuffer write strobe
wr_addr  out  8+X_BITS  {y[7:0], xb[X_BITS-1:0]}
wr_data  out  8  first nibble in [7:4], second nibble in [3:0]
frame_done  out  1  one-cycle pulse at each frame marker while ACTIVE
locked  out  1  high while in ACTIVE
overrun  out  1  sticky error flag
clear_err  in  1  clears overrun

Behaviour:
- Reset is synchronous, active-high, on clk. Reset values: wr_en=0, wr_addr=0, wr_data=0, frame_done=0, locked=0, overrun=0; state=WAIT_FRAME; y=0, xb=0, nibble phase=0, synchronizers cleared to 0.
- All five lcd_* inputs pass through a 2-flop synchronizer, then one history flop. Data takes the same path, so the nibble is sampled aligned with the clock edge.
- Events (synced vs history):
  - clk_rise: lcd_clk 0->1.
  - row_rise: lcd_row 0->1.
  - frame_mark: row_rise while synced lcd_frame=1.
- Minimum input pulse: lcd_clk high and low each >=2 clk cycles. Narrower pulses are not required to be captured.
- States:
  - WAIT_FRAME: ignore clk_rise and row_rise. On frame_mark: y=0, xb=0, phase=0, go to ACTIVE. No frame_done pulse on this entry.
  - ACTIVE: locked=1.
    - On clk_rise, phase 0: hold nibble N0, phase=1.
    - On clk_rise, phase 1: wr_data={N0,N1} (each nibble inverted if INVERT), wr_addr={y,xb}, wr_en=1 for one cycle, xb+=1, phase=0.
    - On row_rise without frame: y+=1, xb=0, phase=0.
    - On frame_mark: y=0, xb=0, phase=0, frame_done=1 for one cycle.
- Latency: wr_en is high in cycle N+3, where N is the first clk edge whose first synchronizer flop samples lcd_clk=1 for the second nibble.
- Boundaries:
  - Row overflow: a clk_rise when xb*2+phase >= WIDTH is dropped and sets overrun.
  - Frame overflow: any write while y >= HEIGHT is suppressed and sets overrun. y saturates at 255.
  - Row/frame marker with phase=1: the partial byte is dropped (no write) and overrun is set.
  - clk_rise and row_rise in the same cycle: the row event wins and the nibble is dropped, with no overrun.
  - lcd_enable low (synced) in any state: go to WAIT_FRAME, wr_en=0, locked=0. Writes already issued stand.
  - clear_err and a new error in the same cycle: overrun stays set.
  - reset mid-row: immediate return to reset values. No write is issued for a held nibble.
- y is 8 bits. xb is X_BITS bits and never wraps, because overflow is caught first.

Test Plan:
- Sync acquire: hold enable=1, send 3 rows of data with no frame marker -> no wr_en, locked=0. Then frame+row pulse -> locked=1, no frame_done pulse.
- Byte assembly: after lock, nibbles 0x1,0x2 with lcd_data inverted (0xE,0xD), INVERT=1 -> one wr_en, wr_data=0x12, wr_addr=0. Check wr_en lands exactly 3 cycles after the second lcd_clk rise is first sampled.
- Full frame: 240 rows x 160 nibbles of pattern byte=(y+xb)&0xFF, then frame marker -> 19200 writes, last wr_addr={239,79}, one frame_done pulse, overrun=0.
- Row overflow: 162 clock pulses in one row -> 80 writes, overrun=1. clear_err -> overrun=0.
- Odd nibble: 3 nibbles then row pulse -> 1 write, overrun=1, next row starts at wr_addr={y+1,0}.
- Enable/reset mid-frame: drop lcd_enable at row 10 -> locked=0 and no writes until the next frame marker. Assert reset between nibbles -> all outputs return to 0 and no spurious write.
